// File: rtl/safe_lock_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : safe_lock_ctrl
//  Purpose  : Combination-lock controller. The user dials a DIGITS-long code
//             with one-cycle INC/NEXT pulses. The entry is compared against a
//             reprogrammable code register. Wrong attempts are counted, and
//             MAX_TRIES consecutive failures start a LOCKOUT_CYC-cycle alarm.
//  Ports    : CLK    - system clock
//             RST_N  - asynchronous active-low reset
//             INC    - pulse: increment the digit being dialled
//             NEXT   - pulse: accept the digit being dialled
//             CLR    - pulse: clear entry / relock / abort programming
//             PROG   - pulse: enter programming (only while open)
//             CUR    - digit currently being dialled
//             POS    - index of the digit being entered
//             TRIES  - consecutive wrong attempts
//             STATE  - 0=ENTRY 1=CHECK 2=OPEN 3=LOCKOUT 4=PROGRAM
//             OPEN   - lock open
//             ALARM  - lockout active
//             ERR    - one-cycle pulse on a wrong code
//  Revision : 1.0 - initial release
// ============================================================================
module safe_lock_ctrl #(
  parameter int DIGITS      = 4,
  parameter int DIGIT_W     = 4,
  parameter int MAX_TRIES   = 3,
  parameter int LOCKOUT_CYC = 50000000,
  parameter logic [DIGITS*DIGIT_W-1:0] DEFAULT_CODE = 16'h1234,
  localparam int POS_W = $clog2(DIGITS),
  localparam int TRY_W = $clog2(MAX_TRIES+1)
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               INC,
  input  logic               NEXT,
  input  logic               CLR,
  input  logic               PROG,
  output logic [DIGIT_W-1:0] CUR,
  output logic [POS_W-1:0]   POS,
  output logic [TRY_W-1:0]   TRIES,
  output logic [2:0]         STATE,
  output logic               OPEN,
  output logic               ALARM,
  output logic               ERR
);

  localparam int TMR_W  = $clog2(LOCKOUT_CYC);
  localparam int CODE_W = DIGITS*DIGIT_W;

  localparam logic [POS_W-1:0] c_last_pos  = POS_W'(DIGITS-1);
  localparam logic [TMR_W-1:0] c_tmr_load  = TMR_W'(LOCKOUT_CYC-1);
  localparam logic [TRY_W-1:0] c_max_tries = TRY_W'(MAX_TRIES);

  typedef enum logic [2:0] {
    ST_ENTRY   = 3'd0,
    ST_CHECK   = 3'd1,
    ST_OPEN    = 3'd2,
    ST_LOCKOUT = 3'd3,
    ST_PROGRAM = 3'd4
  } state_t;

  state_t              r_state,  w_state_nxt;
  logic [DIGIT_W-1:0]  r_cur,    w_cur_nxt;
  logic [POS_W-1:0]    r_pos,    w_pos_nxt;
  logic [TRY_W-1:0]    r_tries,  w_tries_nxt;
  logic                r_open,   w_open_nxt;
  logic                r_alarm,  w_alarm_nxt;
  logic                r_err,    w_err_nxt;
  logic                r_mism,   w_mism_nxt;
  logic [TMR_W-1:0]    r_timer,  w_timer_nxt;
  logic [CODE_W-1:0]   r_code,   w_code_nxt;
  logic [CODE_W-1:0]   r_shadow, w_shadow_nxt;

  logic [DIGIT_W-1:0]  w_code_dig;   // stored digit at the current position
  logic [CODE_W-1:0]   w_shadow_wr;  // shadow with the current digit merged in
  logic [TRY_W-1:0]    w_tries_inc;
  logic                w_last;

  assign w_code_dig  = r_code[int'(r_pos)*DIGIT_W +: DIGIT_W];
  assign w_tries_inc = r_tries + TRY_W'(1);
  assign w_last      = (r_pos == c_last_pos);

  // The final programming digit must land in the code register on the same
  // edge it is accepted, so the merge is done combinationally.
  always_comb begin
    w_shadow_wr = r_shadow;
    w_shadow_wr[int'(r_pos)*DIGIT_W +: DIGIT_W] = r_cur;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state  <= ST_ENTRY;
      r_cur    <= '0;
      r_pos    <= '0;
      r_tries  <= '0;
      r_open   <= 1'b0;
      r_alarm  <= 1'b0;
      r_err    <= 1'b0;
      r_mism   <= 1'b0;
      r_timer  <= '0;
      r_code   <= DEFAULT_CODE;
      r_shadow <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cur    <= w_cur_nxt;
      r_pos    <= w_pos_nxt;
      r_tries  <= w_tries_nxt;
      r_open   <= w_open_nxt;
      r_alarm  <= w_alarm_nxt;
      r_err    <= w_err_nxt;
      r_mism   <= w_mism_nxt;
      r_timer  <= w_timer_nxt;
      r_code   <= w_code_nxt;
      r_shadow <= w_shadow_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cur_nxt    = r_cur;
    w_pos_nxt    = r_pos;
    w_tries_nxt  = r_tries;
    w_open_nxt   = r_open;
    w_alarm_nxt  = r_alarm;
    w_err_nxt    = 1'b0;           // ERR is a single-cycle pulse
    w_mism_nxt   = r_mism;
    w_timer_nxt  = r_timer;
    w_code_nxt   = r_code;
    w_shadow_nxt = r_shadow;

    case (r_state)
      ST_ENTRY: begin
        if (CLR) begin
          w_cur_nxt  = '0;
          w_pos_nxt  = '0;
          w_mism_nxt = 1'b0;
        end else if (NEXT) begin
          // Mismatch is accumulated so a wrong digit is not revealed early.
          w_mism_nxt = r_mism | (r_cur != w_code_dig);
          w_cur_nxt  = '0;
          if (w_last) begin
            w_pos_nxt   = '0;
            w_state_nxt = ST_CHECK;
          end else begin
            w_pos_nxt = r_pos + POS_W'(1);
          end
        end else if (INC) begin
          w_cur_nxt = r_cur + DIGIT_W'(1);
        end
      end

      ST_CHECK: begin
        w_mism_nxt = 1'b0;
        if (!r_mism) begin
          w_state_nxt = ST_OPEN;
          w_tries_nxt = '0;
          w_open_nxt  = 1'b1;
        end else begin
          w_err_nxt   = 1'b1;
          w_tries_nxt = w_tries_inc;
          if (w_tries_inc == c_max_tries) begin
            w_state_nxt = ST_LOCKOUT;
            w_timer_nxt = c_tmr_load;
            w_alarm_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_ENTRY;
          end
        end
      end

      ST_OPEN: begin
        if (CLR) begin
          w_open_nxt  = 1'b0;
          w_state_nxt = ST_ENTRY;
        end else if (PROG) begin
          w_state_nxt = ST_PROGRAM;
          w_cur_nxt   = '0;
          w_pos_nxt   = '0;
        end
      end

      ST_PROGRAM: begin
        if (CLR) begin
          w_state_nxt = ST_OPEN;
          w_cur_nxt   = '0;
          w_pos_nxt   = '0;
        end else if (NEXT) begin
          w_shadow_nxt = w_shadow_wr;
          w_cur_nxt    = '0;
          if (w_last) begin
            w_code_nxt  = w_shadow_wr;
            w_pos_nxt   = '0;
            w_open_nxt  = 1'b0;
            w_state_nxt = ST_ENTRY;
          end else begin
            w_pos_nxt = r_pos + POS_W'(1);
          end
        end else if (INC) begin
          w_cur_nxt = r_cur + DIGIT_W'(1);
        end
      end

      ST_LOCKOUT: begin
        // Timer is loaded with LOCKOUT_CYC-1, so counting down through 0
        // keeps ALARM high for exactly LOCKOUT_CYC cycles.
        if (r_timer == '0) begin
          w_state_nxt = ST_ENTRY;
          w_alarm_nxt = 1'b0;
          w_tries_nxt = '0;
          w_cur_nxt   = '0;
          w_pos_nxt   = '0;
        end else begin
          w_timer_nxt = r_timer - TMR_W'(1);
        end
      end

      default: begin
        w_state_nxt = ST_ENTRY;
        w_cur_nxt   = '0;
        w_pos_nxt   = '0;
        w_open_nxt  = 1'b0;
        w_alarm_nxt = 1'b0;
        w_mism_nxt  = 1'b0;
      end
    endcase
  end

  assign CUR   = r_cur;
  assign POS   = r_pos;
  assign TRIES = r_tries;
  assign STATE = r_state;
  assign OPEN  = r_open;
  assign ALARM = r_alarm;
  assign ERR   = r_err;

endmodule
`default_nettype wire
